// File: rtl/counter_checker.sv
// counter_checker
// ---------------
// Passive sequence checker that sits on the reading side of an up-counter.
// Each rising clock edge it samples the counter value and the enable that
// drives the counter. From the previous sample it predicts the current one
// and flags any deviation. It also counts mismatches and wrap-arounds, and
// reports when the observed stream has matched long enough to be trusted.
//
// Parameters
//   WIDTH        width of the observed counter bus (arithmetic mod 2^WIDTH)
//   LOCK_CYCLES  consecutive matches in TRACK before locked asserts (1..255)
//   ERR_W        width of error_count / wrap_count (both saturate)
//
// Ports
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   enable       the same enable that is driven to the counter
//   count_in     observed counter output
//   locked       stream verified for >= LOCK_CYCLES consecutive matches
//   error_pulse  one-cycle strobe after each mismatching sample
//   error_count  mismatches since reset, saturating
//   wrap_count   valid (2^WIDTH-1) -> 0 increments observed, saturating
//   expected     predicted value for the sample taken at the next edge (debug)

module counter_checker #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned LOCK_CYCLES = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             error_pulse,
  output logic [ERR_W-1:0] error_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic [WIDTH-1:0] expected
);

  // SYNC discards comparison for one sample; TRACK compares every sample.
  typedef enum logic [0:0] {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [ERR_W-1:0] STAT_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] STAT_ONE = ERR_W'(1);
  localparam logic [7:0]       RUN_MAX  = 8'(LOCK_CYCLES);
  localparam logic [7:0]       RUN_ONE  = 8'd1;

  // Saturating increment shared by the error and wrap statistics.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] val);
    logic [ERR_W-1:0] res;
    if (val == STAT_MAX) begin
      res = val;
    end else begin
      res = val + STAT_ONE;
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic             prev_enable_q, prev_enable_d;
  logic [7:0]       run_q, run_d;
  logic             locked_q, locked_d;
  logic             error_pulse_q, error_pulse_d;
  logic [ERR_W-1:0] error_count_q, error_count_d;
  logic [ERR_W-1:0] wrap_count_q, wrap_count_d;

  logic [WIDTH-1:0] expected_s;
  logic             sample_match_s;
  logic             wrap_step_s;

  // Prediction from the previous sample only; no input reaches it.
  always_comb begin
    expected_s = prev_count_q;
    if (prev_enable_q) begin
      expected_s = prev_count_q + CNT_ONE;
    end else begin
      expected_s = prev_count_q;
    end
  end

  assign sample_match_s = (count_in == expected_s);
  // A matching sample after an enabled step from all-ones is a genuine wrap.
  assign wrap_step_s    = prev_enable_q && (prev_count_q == CNT_MAX);

  // State register and all datapath flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_SYNC;
      prev_count_q  <= '0;
      prev_enable_q <= 1'b0;
      run_q         <= 8'd0;
      locked_q      <= 1'b0;
      error_pulse_q <= 1'b0;
      error_count_q <= '0;
      wrap_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      prev_count_q  <= prev_count_d;
      prev_enable_q <= prev_enable_d;
      run_q         <= run_d;
      locked_q      <= locked_d;
      error_pulse_q <= error_pulse_d;
      error_count_q <= error_count_d;
      wrap_count_q  <= wrap_count_d;
    end
  end

  // Next-state logic: SYNC always hands over to TRACK; a mismatch drops back.
  always_comb begin
    state_d = ST_SYNC;
    case (state_q)
      ST_SYNC: begin
        state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (sample_match_s) begin
          state_d = ST_TRACK;
        end else begin
          state_d = ST_SYNC;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // Output / datapath logic for each state.
  always_comb begin
    // Every sample is captured, including a mismatching one, so the next
    // SYNC cycle re-anchors on the stream the counter is actually producing.
    prev_count_d  = count_in;
    prev_enable_d = enable;
    run_d         = run_q;
    locked_d      = locked_q;
    error_pulse_d = 1'b0;
    error_count_d = error_count_q;
    wrap_count_d  = wrap_count_q;
    case (state_q)
      ST_SYNC: begin
        run_d    = 8'd0;
        locked_d = 1'b0;
      end
      ST_TRACK: begin
        if (sample_match_s) begin
          if (run_q >= RUN_MAX) begin
            run_d = RUN_MAX;
          end else begin
            run_d = run_q + RUN_ONE;
          end
          locked_d = (run_d == RUN_MAX);
          if (wrap_step_s) begin
            wrap_count_d = sat_inc(wrap_count_q);
          end else begin
            wrap_count_d = wrap_count_q;
          end
        end else begin
          run_d         = 8'd0;
          locked_d      = 1'b0;
          error_pulse_d = 1'b1;
          error_count_d = sat_inc(error_count_q);
        end
      end
      default: begin
        run_d    = 8'd0;
        locked_d = 1'b0;
      end
    endcase
  end

  assign locked      = locked_q;
  assign error_pulse = error_pulse_q;
  assign error_count = error_count_q;
  assign wrap_count  = wrap_count_q;
  assign expected    = expected_s;

endmodule
